// File: rtl/text_buffer_writer.sv
// text_buffer_writer
//   Write-side terminal controller for the text-mode character RAM. Takes an
//   ASCII byte stream over valid/ready, keeps a cursor, and drives the RAM
//   write port one cell per cycle. CR, LF, BS and FF are interpreted; other
//   control/high bytes are swallowed. The display reads the RAM elsewhere.
//
// Ports
//   clk_i          system clock, all logic on posedge
//   rst_n_i        synchronous reset, active low
//   char_valid_i   char_data_i is presented
//   char_data_i    ASCII byte
//   char_ready_o   byte accepted when char_valid_i & char_ready_o at posedge
//   wr_en_o        character RAM write strobe
//   wr_addr_o      cell address = row*COLS + col
//   wr_data_o      code to write
//   cursor_col_o   current column, 0..COLS-1
//   cursor_row_o   current row, 0..ROWS-1
//   busy_o         a full-screen or line clear is in progress
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_CLR_ALL  | blanking every cell 0..COLS*ROWS-1, cursor set (0,0) at end
// S_IDLE     | accepting bytes, one per cycle
// S_CLR_LINE | blanking the row the cursor just moved onto

module text_buffer_writer #(
   parameter int         COLS   = 80,
   parameter int         ROWS   = 30,
   parameter int         ADDR_W = 12,
   parameter logic [7:0] BLANK  = 8'h20
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              char_valid_i,
   input  logic [7:0]        char_data_i,
   output logic              char_ready_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [7:0]        wr_data_o,
   output logic [6:0]        cursor_col_o,
   output logic [4:0]        cursor_row_o,
   output logic              busy_o
);

   localparam logic [1:0] S_CLR_ALL  = 2'd0;
   localparam logic [1:0] S_IDLE     = 2'd1;
   localparam logic [1:0] S_CLR_LINE = 2'd2;

   localparam int CELLS = COLS * ROWS;

   localparam logic [ADDR_W-1:0] CLR_ALL_LEFT  = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] CLR_LINE_LEFT = ADDR_W'(COLS - 1);
   localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
   localparam logic [4:0]        LAST_ROW      = 5'(ROWS - 1);

   logic [1:0]        state_q,    state_d;
   logic [6:0]        col_q,      col_d;
   logic [4:0]        row_q,      row_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   // Cells remaining in the current clear; the clear ends when this hits zero.
   logic [ADDR_W-1:0] clr_left_q, clr_left_d;
   logic              wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [7:0]        wr_data_q,  wr_data_d;

   logic       accept;
   logic [4:0] row_next;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] r,
                                                   input logic [6:0] c);
      return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
   endfunction

   assign char_ready_o = (state_q == S_IDLE);
   assign busy_o       = ~char_ready_o;
   assign accept       = char_valid_i & char_ready_o;
   // No scrolling: moving past the bottom row wraps to the top.
   assign row_next     = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      clr_addr_d = clr_addr_q;
      clr_left_d = clr_left_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      case (state_q)
         S_CLR_ALL, S_CLR_LINE: begin
            wr_en_d    = 1'b1;
            wr_addr_d  = clr_addr_q;
            wr_data_d  = BLANK;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            clr_left_d = clr_left_q - ADDR_W'(1);
            if (clr_left_q == '0) begin
               state_d = S_IDLE;
               if (state_q == S_CLR_ALL) begin
                  col_d = 7'd0;
                  row_d = 5'd0;
               end
            end
         end

         S_IDLE: begin
            if (accept) begin
               if (char_data_i >= 8'h20 && char_data_i <= 8'h7E) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cell_addr(row_q, col_q);
                  wr_data_d = char_data_i;
                  if (col_q == LAST_COL) begin
                     col_d      = 7'd0;
                     row_d      = row_next;
                     clr_addr_d = cell_addr(row_next, 7'd0);
                     clr_left_d = CLR_LINE_LEFT;
                     state_d    = S_CLR_LINE;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end else begin
                  case (char_data_i)
                     8'h0D: col_d = 7'd0;
                     8'h0A: begin
                        row_d      = row_next;
                        clr_addr_d = cell_addr(row_next, 7'd0);
                        clr_left_d = CLR_LINE_LEFT;
                        state_d    = S_CLR_LINE;
                     end
                     8'h08: begin
                        if (col_q != 7'd0) begin
                           col_d     = col_q - 7'd1;
                           wr_en_d   = 1'b1;
                           wr_addr_d = cell_addr(row_q, col_q - 7'd1);
                           wr_data_d = BLANK;
                        end
                     end
                     8'h0C: begin
                        clr_addr_d = '0;
                        clr_left_d = CLR_ALL_LEFT;
                        state_d    = S_CLR_ALL;
                     end
                     default: ;
                  endcase
               end
            end
         end

         default: begin
            // Unreachable encoding: recover through a full clear.
            clr_addr_d = '0;
            clr_left_d = CLR_ALL_LEFT;
            state_d    = S_CLR_ALL;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_CLR_ALL;
         col_q      <= 7'd0;
         row_q      <= 5'd0;
         clr_addr_q <= '0;
         clr_left_q <= CLR_ALL_LEFT;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= BLANK;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         clr_addr_q <= clr_addr_d;
         clr_left_q <= clr_left_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign cursor_col_o = col_q;
   assign cursor_row_o = row_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   text_buffer_writer dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .char_valid_i (char_valid),
      .char_data_i  (char_data),
      .char_ready_o (char_ready),
      .wr_en_o      (wr_en),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data),
      .cursor_col_o (cursor_col),
      .cursor_row_o (cursor_row),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int exp_q[$];      // expected writes, packed as addr*256 + data
   int mr = 0, mc = 0; // reference cursor
   int cyc = 0;
   int nwr = 0;
   int t_last = 0, t_prev = 0;
   int last_wr = -1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Every observed write must match the next expected write, in order.
   always @(negedge clk) begin
      int e;
      if (wr_en === 1'b1) begin
         nwr++;
         t_prev  = t_last;
         t_last  = cyc;
         last_wr = int'({wr_addr, wr_data});
         if (exp_q.size() == 0) begin
            chk("unexpected_write", last_wr, -1);
         end else begin
            e = exp_q.pop_front();
            chk("write", last_wr, e);
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic push_w(input int a, input int d);
      exp_q.push_back(a * 256 + d);
   endtask

   task automatic model_clear_all();
      for (int i = 0; i < 2400; i++) push_w(i, 32);
      mr = 0;
      mc = 0;
   endtask

   task automatic model_advance();
      mr = (mr + 1) % 30;
      for (int i = 0; i < 80; i++) push_w(mr * 80 + i, 32);
   endtask

   task automatic model_byte(input int b);
      if (b >= 32 && b <= 126) begin
         push_w(mr * 80 + mc, b);
         if (mc == 79) begin
            mc = 0;
            model_advance();
         end else begin
            mc++;
         end
      end else if (b == 13) begin
         mc = 0;
      end else if (b == 10) begin
         model_advance();
      end else if (b == 8) begin
         if (mc > 0) begin
            mc--;
            push_w(mr * 80 + mc, 32);
         end
      end else if (b == 12) begin
         model_clear_all();
      end
   endtask

   // ---------------- stimulus helpers (called on negedge) ----------------
   task automatic send(input logic [7:0] b);
      int n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      model_byte(int'(b));
      char_valid = 1'b1;
      char_data  = b;
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic settle(input string tag);
      int n = 0;
      while (!(char_ready === 1'b1 && exp_q.size() == 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk({tag, "_timeout"}, exp_q.size(), 0);
      chk({tag, "_col"}, int'(cursor_col), mc);
      chk({tag, "_row"}, int'(cursor_row), mr);
   endtask

   initial begin
      int n0, n;
      int r;
      logic [7:0] b;

      rst_n      = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst_wr_en",   int'(wr_en),      0);
      chk("rst_wr_addr", int'(wr_addr),    0);
      chk("rst_wr_data", int'(wr_data),    32);
      chk("rst_ready",   int'(char_ready), 0);
      chk("rst_busy",    int'(busy),       1);
      chk("rst_col",     int'(cursor_col), 0);
      chk("rst_row",     int'(cursor_row), 0);

      // Power-up clear
      exp_q.delete();
      model_clear_all();
      n0    = nwr;
      rst_n = 1'b1;
      settle("init");
      chk("init_count", nwr - n0, 2400);
      chk("init_busy",  int'(busy), 0);

      // Back-to-back printable bytes
      send(8'h41);
      send(8'h42);
      settle("ab");
      chk("ab_consec", t_last - t_prev, 1);
      chk("ab_col2",   int'(cursor_col), 2);

      // Line wrap into a line clear
      send(8'h0D);
      for (int i = 0; i < 79; i++) send(8'(8'h30 + (i % 40)));
      send(8'h7E);
      n = 0;
      while (char_ready === 1'b0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("line_clr_len", n, 80);
      send(8'h5A);
      settle("wrap");
      chk("wrap_row1", int'(cursor_row), 1);
      chk("wrap_col1", int'(cursor_col), 1);
      chk("wrap_z",    last_wr, 80 * 256 + 8'h5A);

      // Bottom-row LF wraps to row 0
      send(8'h0C);
      settle("ff");
      for (int i = 0; i < 29; i++) send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'h61);
      settle("pre_wrap");
      chk("at_row29", int'(cursor_row), 29);
      send(8'h0A);
      settle("lf_wrap");
      chk("lf_wrap_row0", int'(cursor_row), 0);
      chk("lf_wrap_col5", int'(cursor_col), 5);
      chk("lf_wrap_last", last_wr, 79 * 256 + 32);

      // Backspace at column 0 and mid-line
      send(8'h0D);
      settle("cr");
      n0 = nwr;
      send(8'h08);
      settle("bs0");
      chk("bs0_nowrite", nwr - n0, 0);
      send(8'h0A);
      send(8'h0A);
      send(8'h61);
      send(8'h62);
      send(8'h63);
      send(8'h08);
      settle("bs");
      chk("bs_addr", last_wr, 162 * 256 + 32);
      chk("bs_col2", int'(cursor_col), 2);

      // Reset in the middle of a full clear
      send(8'h0C);
      repeat (1000) @(negedge clk);
      chk("mid_ff_busy", int'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_wr_en",   int'(wr_en),   0);
      chk("mid_rst_wr_addr", int'(wr_addr), 0);
      exp_q.delete();
      model_clear_all();
      n0    = nwr;
      rst_n = 1'b1;
      settle("rst_clear");
      chk("rst_clear_count", nwr - n0, 2400);

      // Randomized byte stream
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70)      b = 8'($urandom_range(32, 126));
         else if (r < 77) b = 8'h0D;
         else if (r < 84) b = 8'h0A;
         else if (r < 92) b = 8'h08;
         else if (r < 94) b = 8'h0C;
         else if ($urandom_range(0, 1) == 1) b = 8'(8'h80 + $urandom_range(0, 127));
         else b = 8'h1B;
         send(b);
         if ($urandom_range(0, 1) == 1) settle("rnd");
      end
      settle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
